// File: rtl/expr_checker.sv
// -----------------------------------------------------------------------------
// expr_checker
//
// Streaming recogniser for infix arithmetic strings. One ASCII character is
// consumed on every rising clock edge where in_valid is high. After that edge,
// the outputs show whether the prefix received so far is a complete,
// well-formed expression.
//
// Grammar (informal):
//   expr    := operand (OP operand)*
//   operand := DIG{1..MAX_DIGITS} | '(' expr ')'
//
// Parameters
//   MAX_DIGITS  : max digits per operand (1..15)
//   OP_EXT      : 1 -> '-' and '/' are also binary operators
//   ALLOW_PAREN : 1 -> '(' and ')' are legal
//   DEPTH_W     : nesting counter width (max depth 2^DEPTH_W-1)
//   CNT_W       : operator counter width (saturating)
//
// Ports
//   clk       : rising-edge clock
//   clr       : synchronous active-high reset, has priority over in_valid
//   in_valid  : in is consumed only when high; otherwise everything holds
//   in        : ASCII character
//   out       : prefix so far is a complete valid expression
//   err       : sticky, an illegal character or sequence has been seen
//   depth     : current open-parenthesis nesting
//   op_cnt    : number of binary operators accepted (saturating)
//   state_dbg : current FSM state (0 START, 1 NUM, 2 CLOSE, 3 ERR)
//
// Handshake: there is no back-pressure. A character is taken exactly on a
// rising edge where in_valid=1 and clr=0; the recogniser is always ready.
// -----------------------------------------------------------------------------
module expr_checker #(
    parameter int MAX_DIGITS  = 1,
    parameter int OP_EXT      = 0,
    parameter int ALLOW_PAREN = 1,
    parameter int DEPTH_W     = 3,
    parameter int CNT_W       = 8
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               in_valid,
    input  logic [7:0]         in,
    output logic               out,
    output logic               err,
    output logic [DEPTH_W-1:0] depth,
    output logic [CNT_W-1:0]   op_cnt,
    output logic [1:0]         state_dbg
);

    typedef enum logic [1:0] {
        S_START = 2'd0,   // expecting an operand
        S_NUM   = 2'd1,   // inside a numeric operand
        S_CLOSE = 2'd2,   // just after ')'
        S_ERR   = 2'd3    // absorbing error state
    } state_t;

    localparam logic [3:0]         MAXD      = 4'(MAX_DIGITS);
    localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;
    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

    state_t             state_q, state_d;
    logic [3:0]         dcnt_q, dcnt_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic [CNT_W-1:0]   opcnt_q, opcnt_d;
    logic               out_q, out_d;
    logic               err_q, err_d;

    // Character classification
    logic is_dig, is_op, is_lp, is_rp;

    always_comb begin
        is_dig = (in >= 8'h30) && (in <= 8'h39);
        is_op  = (in == 8'h2B) || (in == 8'h2A) ||
                 ((OP_EXT != 0) && ((in == 8'h2D) || (in == 8'h2F)));
        is_lp  = (ALLOW_PAREN != 0) && (in == 8'h28);
        is_rp  = (ALLOW_PAREN != 0) && (in == 8'h29);
    end

    // Next-state logic. Defaults hold everything, so in_valid=0 and S_ERR
    // both leave depth/op_cnt frozen without any extra gating.
    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        depth_d = depth_q;
        opcnt_d = opcnt_q;

        if (in_valid) begin
            case (state_q)
                S_START: begin
                    if (is_dig) begin
                        state_d = S_NUM;
                        dcnt_d  = 4'd1;
                    end else if (is_lp) begin
                        // depth never wraps: overflow is an error
                        if (depth_q == DEPTH_MAX) begin
                            state_d = S_ERR;
                        end else begin
                            state_d = S_START;
                            dcnt_d  = 4'd0;
                            depth_d = depth_q + 1'b1;
                        end
                    end else begin
                        state_d = S_ERR;
                    end
                end

                S_NUM: begin
                    if (is_dig) begin
                        if (dcnt_q < MAXD) begin
                            dcnt_d = dcnt_q + 4'd1;
                        end else begin
                            state_d = S_ERR;
                        end
                    end else if (is_op) begin
                        state_d = S_START;
                        dcnt_d  = 4'd0;
                        if (opcnt_q != CNT_MAX) opcnt_d = opcnt_q + 1'b1;
                    end else if (is_rp && (depth_q != '0)) begin
                        state_d = S_CLOSE;
                        depth_d = depth_q - 1'b1;
                    end else begin
                        state_d = S_ERR;
                    end
                end

                S_CLOSE: begin
                    if (is_op) begin
                        state_d = S_START;
                        dcnt_d  = 4'd0;
                        if (opcnt_q != CNT_MAX) opcnt_d = opcnt_q + 1'b1;
                    end else if (is_rp && (depth_q != '0)) begin
                        state_d = S_CLOSE;
                        depth_d = depth_q - 1'b1;
                    end else begin
                        state_d = S_ERR;
                    end
                end

                default: begin
                    state_d = S_ERR;
                end
            endcase
        end

        // Outputs are derived from the next state so they land in the same
        // edge as the character that caused them.
        err_d = (state_d == S_ERR);
        out_d = ((state_d == S_NUM) || (state_d == S_CLOSE)) && (depth_d == '0);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_START;
            dcnt_q  <= 4'd0;
            depth_q <= '0;
            opcnt_q <= '0;
            out_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            depth_q <= depth_d;
            opcnt_q <= opcnt_d;
            out_q   <= out_d;
            err_q   <= err_d;
        end
    end

    assign out       = out_q;
    assign err       = err_q;
    assign depth     = depth_q;
    assign op_cnt    = opcnt_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_expr_checker.sv
module tb_expr_checker;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in = 8'h00;

    always #5 clk = ~clk;

    // Six instances share the stimulus; each vector names the one it checks.
    // 0: defaults  1: MAX_DIGITS=3  2: OP_EXT=1  3: DEPTH_W=2  4: CNT_W=2
    // 5: ALLOW_PAREN=0
    localparam int NI = 6;
    logic       out_a [NI];
    logic       err_a [NI];
    logic [2:0] depth_a [NI];
    logic [7:0] op_a [NI];
    logic [1:0] st_a [NI];

    logic [1:0] dep3;
    logic [1:0] op4;

    expr_checker u0 (.clk(clk), .clr(clr), .in_valid(in_valid), .in(in),
        .out(out_a[0]), .err(err_a[0]), .depth(depth_a[0]), .op_cnt(op_a[0]), .state_dbg(st_a[0]));
    expr_checker #(.MAX_DIGITS(3)) u1 (.clk(clk), .clr(clr), .in_valid(in_valid), .in(in),
        .out(out_a[1]), .err(err_a[1]), .depth(depth_a[1]), .op_cnt(op_a[1]), .state_dbg(st_a[1]));
    expr_checker #(.OP_EXT(1)) u2 (.clk(clk), .clr(clr), .in_valid(in_valid), .in(in),
        .out(out_a[2]), .err(err_a[2]), .depth(depth_a[2]), .op_cnt(op_a[2]), .state_dbg(st_a[2]));
    expr_checker #(.DEPTH_W(2)) u3 (.clk(clk), .clr(clr), .in_valid(in_valid), .in(in),
        .out(out_a[3]), .err(err_a[3]), .depth(dep3), .op_cnt(op_a[3]), .state_dbg(st_a[3]));
    expr_checker #(.CNT_W(2)) u4 (.clk(clk), .clr(clr), .in_valid(in_valid), .in(in),
        .out(out_a[4]), .err(err_a[4]), .depth(depth_a[4]), .op_cnt(op4), .state_dbg(st_a[4]));
    expr_checker #(.ALLOW_PAREN(0)) u5 (.clk(clk), .clr(clr), .in_valid(in_valid), .in(in),
        .out(out_a[5]), .err(err_a[5]), .depth(depth_a[5]), .op_cnt(op_a[5]), .state_dbg(st_a[5]));

    assign depth_a[3] = {1'b0, dep3};
    assign op_a[4]    = {6'b0, op4};

    // ---------------- scoreboard ----------------
    localparam int W = 13;  // {out, err, depth[2:0], op_cnt[7:0]}
    logic [W-1:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int   inst;
        bit   clr_first;
        byte  ch;
        bit   e_out;
        bit   e_err;
        int   e_depth;
        int   e_op;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int inst, input bit c, input byte ch, input bit o,
                       input bit e, input int d, input int op);
        vec_t v;
        v.inst = inst; v.clr_first = c; v.ch = ch;
        v.e_out = o; v.e_err = e; v.e_depth = d; v.e_op = op;
        vecs.push_back(v);
    endtask

    function automatic logic [W-1:0] pack(input bit o, input bit e, input int d, input int op);
        return {o, e, d[2:0], op[7:0]};
    endfunction

    task automatic check(input string name, input int inst);
        logic [W-1:0] exp_v;
        logic [W-1:0] got;
        exp_v = exp_q.pop_front();
        got   = {out_a[inst], err_a[inst], depth_a[inst], op_a[inst]};
        n_tests++;
        if (got !== exp_v) begin
            n_fail++;
            $display("FAIL %s inst%0d: got out=%0d err=%0d depth=%0d op=%0d, need out=%0d err=%0d depth=%0d op=%0d",
                     name, inst, got[12], got[11], got[10:8], got[7:0],
                     exp_v[12], exp_v[11], exp_v[10:8], exp_v[7:0]);
        end
    endtask

    task automatic check_state(input string name, input logic [1:0] need);
        n_tests++;
        if (st_a[0] !== need) begin
            n_fail++;
            $display("FAIL %s: got state=%0d, need state=%0d", name, st_a[0], need);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_clr();
        @(negedge clk);
        clr = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    task automatic send(input byte ch);
        @(negedge clk);
        in_valid = 1'b1;
        in = ch;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // ---------------- test ----------------
    initial begin
        // "1+2*3+" on defaults
        add(0,1,"1",1,0,0,0); add(0,0,"+",0,0,0,1); add(0,0,"2",1,0,0,1);
        add(0,0,"*",0,0,0,2); add(0,0,"3",1,0,0,2); add(0,0,"+",0,0,0,3);
        // digit limit, MAX_DIGITS=1 then 3
        add(0,1,"4",1,0,0,0); add(0,0,"5",0,1,0,0);
        add(1,1,"4",1,0,0,0); add(1,0,"5",1,0,0,0); add(1,0,"6",1,0,0,0);
        add(1,0,"7",0,1,0,0);
        // "(1+2)*3" then stray ")"
        add(0,1,"(",0,0,1,0); add(0,0,"1",0,0,1,0); add(0,0,"+",0,0,1,1);
        add(0,0,"2",0,0,1,1); add(0,0,")",1,0,0,1); add(0,0,"*",0,0,0,2);
        add(0,0,"3",1,0,0,2); add(0,0,")",0,1,0,2);
        // nested close and digit after ')'
        add(0,1,"(",0,0,1,0); add(0,0,"(",0,0,2,0); add(0,0,"1",0,0,2,0);
        add(0,0,")",0,0,1,0); add(0,0,")",1,0,0,0); add(0,0,"2",0,1,0,0);
        // depth overflow with DEPTH_W=2
        add(3,1,"(",0,0,1,0); add(3,0,"(",0,0,2,0); add(3,0,"(",0,0,3,0);
        add(3,0,"(",0,1,3,0);
        // OP_EXT off / on
        add(0,1,"1",1,0,0,0); add(0,0,"-",0,1,0,0);
        add(2,1,"1",1,0,0,0); add(2,0,"-",0,0,0,1); add(2,0,"2",1,0,0,1);
        add(2,0,"/",0,0,0,2); add(2,0,"9",1,0,0,2);
        // op_cnt freezes on error
        add(0,1,"1",1,0,0,0); add(0,0,"+",0,0,0,1); add(0,0,"a",0,1,0,1);
        add(0,0,"3",0,1,0,1);
        // saturation with CNT_W=2
        add(4,1,"1",1,0,0,0); add(4,0,"+",0,0,0,1); add(4,0,"1",1,0,0,1);
        add(4,0,"+",0,0,0,2); add(4,0,"1",1,0,0,2); add(4,0,"+",0,0,0,3);
        add(4,0,"1",1,0,0,3); add(4,0,"+",0,0,0,3); add(4,0,"1",1,0,0,3);
        // parens illegal when disabled
        add(5,1,"(",0,1,0,0);
        add(5,1,"1",1,0,0,0); add(5,0,")",0,1,0,0);

        // reset state
        do_clr();
        for (int i = 0; i < NI; i++) begin
            exp_q.push_back(pack(0,0,0,0));
            check("reset", i);
        end
        check_state("reset_state", 2'd0);

        // table-driven vectors
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].clr_first) do_clr();
            send(vecs[i].ch);
            exp_q.push_back(pack(vecs[i].e_out, vecs[i].e_err, vecs[i].e_depth, vecs[i].e_op));
            check($sformatf("vec%0d", i), vecs[i].inst);
        end

        // hold: "1+" then in_valid low with garbage on in
        do_clr();
        send("1");
        send("+");
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in = 8'($urandom_range(0, 255));
            @(posedge clk);
            #1;
            exp_q.push_back(pack(0,0,0,1));
            check($sformatf("hold%0d", k), 0);
        end
        check_state("hold_state", 2'd0);
        send("2");
        exp_q.push_back(pack(1,0,0,1));
        check("after_hold", 0);

        // error, then clr together with in_valid
        send("a");
        exp_q.push_back(pack(0,1,0,1));
        check("to_err", 0);
        check_state("err_state", 2'd3);
        @(negedge clk);
        clr = 1'b1;
        in_valid = 1'b1;
        in = "7";
        @(posedge clk);
        #1;
        clr = 1'b0;
        in_valid = 1'b0;
        exp_q.push_back(pack(0,0,0,0));
        check("clr_priority", 0);
        check_state("clr_state", 2'd0);
        send("7");
        exp_q.push_back(pack(1,0,0,0));
        check("after_clr", 0);
        check_state("num_state", 2'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
